// File: rtl/mode_1_rx.sv
// Decoder for the mode_1 run/fall marker stream. It rebuilds the source level,
// measures each run length into a one-entry valid/ready slot, and flags illegal marker sequences.
//
// state | meaning
// IDLE  | no run in progress, waiting for r
// RUN   | r seen on consecutive cycles, counting the run length
// GAP   | f just seen; the next cycle must be idle
module mode_1_rx #(
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r,
  input  logic          f,
  output logic          lvl,
  output logic [LW-1:0] len,
  output logic          len_vld,
  input  logic          len_rdy,
  output logic          ovf,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] len_nxt;
  logic          len_vld_nxt;
  logic          ovf_nxt;
  logic          err_nxt;
  logic [1:0]    err_code_nxt;
  logic          capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lvl      <= 1'b0;
      len      <= '0;
      len_vld  <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lvl      <= (state_nxt == RUN);
      len      <= len_nxt;
      len_vld  <= len_vld_nxt;
      ovf      <= ovf_nxt;
      err      <= err_nxt;
      err_code <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    capture      = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = 2'd0;
    len_nxt      = len;
    len_vld_nxt  = len_vld;
    ovf_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (r && !f) begin
          state_nxt = RUN;
          cnt_nxt   = LW'(1);
        end else if (f) begin
          err_nxt      = 1'b1;
          err_code_nxt = r ? 2'd2 : 2'd1;
        end
      end
      RUN: begin
        if (r && !f) begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        end else if (!r && f) begin
          state_nxt = GAP;
          capture   = 1'b1;
        end else begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = (r && f) ? 2'd2 : 2'd3;
        end
      end
      GAP: begin
        state_nxt = IDLE;
        if (r || f) begin
          err_nxt      = 1'b1;
          err_code_nxt = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A capture may replace the held result only if the consumer takes it this cycle.
    if (capture) begin
      if (!len_vld || len_rdy) begin
        len_nxt     = cnt;
        len_vld_nxt = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (len_vld && len_rdy) begin
      len_vld_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_1_rx.sv
// Self-checking bench for mode_1_rx: directed test-plan sequences plus random marker
// streams, compared every cycle against a run-length reference model.
module tb_mode_1_rx;
  localparam int LW   = 8;
  localparam int MAXV = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r = 1'b0;
  logic          f = 1'b0;
  logic          len_rdy = 1'b0;
  logic          lvl;
  logic [LW-1:0] len;
  logic          len_vld;
  logic          ovf;
  logic          err;
  logic [1:0]    err_code;

  mode_1_rx #(.LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .f(f), .lvl(lvl), .len(len),
    .len_vld(len_vld), .len_rdy(len_rdy), .ovf(ovf), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: run length as an unbounded integer, saturated only when reported.
  int m_run_len = 0;
  bit m_after_fall = 0;
  bit m_full = 0;
  int m_val = 0;
  bit e_ovf = 0;
  bit e_err = 0;
  int e_code = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rr, input bit ff, input bit rdy, input bit rst);
    int captured;
    captured = -1;
    e_ovf = 0;
    e_err = 0;
    e_code = 0;
    if (rst) begin
      m_run_len = 0; m_after_fall = 0; m_full = 0; m_val = 0;
      return;
    end
    if (m_after_fall) begin
      m_after_fall = 0;
      if (rr || ff) begin e_err = 1; e_code = 0; end
    end else if (m_run_len > 0) begin
      if (rr && !ff) m_run_len++;
      else if (!rr && ff) begin
        captured = (m_run_len > MAXV) ? MAXV : m_run_len;
        m_run_len = 0;
        m_after_fall = 1;
      end else begin
        e_err = 1; e_code = (rr && ff) ? 2 : 3;
        m_run_len = 0;
      end
    end else begin
      if (rr && !ff) m_run_len = 1;
      else if (ff) begin e_err = 1; e_code = rr ? 2 : 1; end
    end
    if (captured >= 0) begin
      if (!m_full || rdy) begin m_val = captured; m_full = 1; end
      else e_ovf = 1;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  task automatic step(input bit rr, input bit ff, input bit rdy);
    r = rr; f = ff; len_rdy = rdy;
    @(posedge clk);
    model(rr, ff, rdy, !rst_n);
    #1;
    chk("lvl", lvl, m_run_len > 0);
    chk("len_vld", len_vld, m_full);
    chk("len", len, m_val);
    chk("ovf", ovf, e_ovf);
    chk("err", err, e_err);
    if (e_err) chk("err_code", err_code, e_code);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    step(1, 0, 0);
    step(0, 1, 0);
    chk("reset_lvl", lvl, 0);
    chk("reset_len", len, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    idle(2, 0);

    // Legal run of 5, consumer ready
    run(5, 1);
    chk("run5_lvl_high", lvl, 1);
    step(0, 1, 1);
    chk("run5_len", len, 5);
    chk("run5_vld", len_vld, 1);
    idle(1, 1);
    chk("run5_vld_drop", len_vld, 0);
    idle(2, 1);

    // Back-to-back runs, stalled consumer
    run(3, 0); step(0, 1, 0); idle(1, 0);
    run(2, 0); step(0, 1, 0);
    chk("stall_ovf", ovf, 1);
    chk("stall_len_held", len, 3);
    idle(1, 0);
    chk("stall_ovf_single", ovf, 0);
    idle(1, 1);
    chk("stall_vld_drop", len_vld, 0);
    idle(2, 0);

    // Saturation
    run(MAXV + 5, 1); step(0, 1, 1);
    chk("sat_len", len, MAXV);
    chk("sat_err", err, 0);
    idle(2, 1);

    // Protocol errors
    step(0, 1, 0);
    chk("orphan_code", err_code, 1);
    idle(1, 0);
    run(2, 0); step(1, 1, 0);
    chk("collision_code", err_code, 2);
    chk("collision_lvl", lvl, 0);
    idle(1, 0);
    run(3, 0); step(0, 0, 0);
    chk("trunc_code", err_code, 3);
    run(2, 0); step(0, 1, 0);
    step(1, 0, 0);
    chk("gap_err", err, 1);
    chk("gap_code", err_code, 0);
    chk("gap_no_run", lvl, 0);
    idle(2, 1);

    // Reset mid-run
    run(4, 0);
    rst_n = 1'b0;
    step(1, 0, 0);
    chk("midreset_lvl", lvl, 0);
    rst_n = 1'b1;
    idle(1, 0);
    run(2, 0); step(0, 1, 0);
    chk("midreset_len", len, 2);
    idle(1, 1);
    idle(1, 0);

    // Capture with simultaneous accept
    run(7, 0); step(0, 1, 0); idle(1, 0);
    run(9, 0); step(0, 1, 1);
    chk("swap_len", len, 9);
    chk("swap_vld", len_vld, 1);
    chk("swap_ovf", ovf, 0);
    idle(2, 1);

    // Random legal encoder traffic with random consumer stalls
    for (int k = 0; k < 150; k++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) step(1, 0, $urandom_range(0, 3) == 0);
      step(0, 1, $urandom_range(0, 1));
      idle($urandom_range(1, 3), $urandom_range(0, 1));
    end

    // Fully random markers, including resets
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom_range(0, 1));
    end
    rst_n = 1'b1;
    idle(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
